// File: rtl/sat_pkg.sv
// Shared saturation helpers for the signed window accumulator.
// Limits are constant functions so they can size localparams at elaboration.
package sat_pkg;

   localparam int SAT_W = 4;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

   // Returns {sat_flag, sum[SAT_W-1:0]} for a single clamped two's-complement add.
   function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b);
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] max_s;
      logic signed [SAT_W:0] min_s;
      max_s = (SAT_W + 1)'(sat_max(SAT_W));
      min_s = (SAT_W + 1)'(sat_min(SAT_W));
      s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
      if (s > max_s) begin
         return {1'b1, max_s[SAT_W-1:0]};
      end else if (s < min_s) begin
         return {1'b1, min_s[SAT_W-1:0]};
      end
      return {1'b0, s[SAT_W-1:0]};
   endfunction

endpackage

// File: rtl/sat_window_accumulator_if.sv
// Sample-in / result-out handshake bundle for the window accumulator.
// master = source+sink side, slave = the accumulator itself.
interface sat_window_accumulator_if #(
   parameter int W = 4
);
   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_data;
   logic                out_sat;

   modport master (
      output clear,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  clear,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat
   );
endinterface

// File: rtl/sat_add_step.sv
// One combinational accumulate step: a + b evaluated at W+1 bits, clamped to W bits.
// sat_o flags that the clamp engaged on this step.
module sat_add_step
   import sat_pkg::*;
#(
   parameter int W = 4
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o,
   output logic                sat_o
);

   localparam logic signed [W:0] MAX_S = (W + 1)'(sat_max(W));
   localparam logic signed [W:0] MIN_S = (W + 1)'(sat_min(W));

   function automatic logic [W:0] clamp(input logic signed [W:0] s);
      if (s > MAX_S) begin
         return {1'b1, MAX_S[W-1:0]};
      end else if (s < MIN_S) begin
         return {1'b1, MIN_S[W-1:0]};
      end
      return {1'b0, s[W-1:0]};
   endfunction

   logic signed [W:0] wide_sum;
   logic [W:0]        clamped;

   assign wide_sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};
   assign clamped  = clamp(wide_sum);
   assign sum_o    = clamped[W-1:0];
   assign sat_o    = clamped[W];

endmodule

// File: rtl/sat_window_accumulator.sv
// Accumulates N signed samples per window with per-step saturation and a sticky flag,
// holding each result in a one-deep output register that reloads on handoff.
module sat_window_accumulator
   import sat_pkg::*;
#(
   parameter int W = 4,
   parameter int N = 4
) (
   input logic                    clk,
   input logic                    rst,
   sat_window_accumulator_if.slave bus
);

   localparam int                 CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(N - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic signed [W-1:0] acc_q, acc_d;
   logic                sat_acc_q, sat_acc_d;
   logic                out_valid_q, out_valid_d;
   logic signed [W-1:0] out_data_q, out_data_d;
   logic                out_sat_q, out_sat_d;

   logic signed [W-1:0] step_sum;
   logic                step_sat;
   logic                last;
   logic                in_ready;
   logic                accept;

   sat_add_step #(.W(W)) u_step (
      .a_i   (acc_q),
      .b_i   (bus.in_data),
      .sum_o (step_sum),
      .sat_o (step_sat)
   );

   // Only the final sample of a window needs room in the output register.
   assign last     = (cnt_q == LAST_CNT);
   assign in_ready = ~bus.clear & (~last | ~out_valid_q | bus.out_ready);
   assign accept   = bus.in_valid & in_ready;

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      sat_acc_d   = sat_acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (bus.clear) begin
         cnt_d     = '0;
         acc_d     = '0;
         sat_acc_d = 1'b0;
      end else if (accept) begin
         if (last) begin
            // A same-cycle handoff and reload leaves out_valid high.
            out_valid_d = 1'b1;
            out_data_d  = step_sum;
            out_sat_d   = sat_acc_q | step_sat;
            cnt_d       = '0;
            acc_d       = '0;
            sat_acc_d   = 1'b0;
         end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            acc_d     = step_sum;
            sat_acc_d = sat_acc_q | step_sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         sat_acc_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         sat_acc_q   <= sat_acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sat_window_accumulator.sv
// Directed and randomized bench for sat_window_accumulator (W=4, N=4) against a
// queue-based window model that folds each completed window with per-step clamping.
module tb_sat_window_accumulator;

   localparam int W    = 4;
   localparam int N    = 4;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));

   logic clk;
   logic rst;

   sat_window_accumulator_if #(.W(W)) bus ();

   sat_window_accumulator #(.W(W), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  n_dut_ho = 0;
   int  win_q[$];
   bit  m_full = 1'b0;
   int  m_out  = 0;
   bit  m_osat = 1'b0;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Whole-window result: running sum clamped after every addition.
   task automatic fold_window(output int res, output bit sat);
      int s;
      s   = 0;
      sat = 1'b0;
      foreach (win_q[i]) begin
         s = s + win_q[i];
         if (s > MAXV) begin
            s = MAXV; sat = 1'b1;
         end else if (s < MINV) begin
            s = MINV; sat = 1'b1;
         end
      end
      res = s;
   endtask

   // Called at a negedge: drive, check ready, advance the model, check outputs next negedge.
   task automatic cycle(input bit v, input int d, input bit ordy, input bit clr);
      bit exp_rdy;
      int res;
      bit sat;
      bus.in_valid  = v;
      bus.in_data   = W'(d);
      bus.out_ready = ordy;
      bus.clear     = clr;
      #1;
      exp_rdy = !clr && ((win_q.size() != N - 1) || !m_full || ordy);
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      if (bus.out_valid === 1'b1 && ordy) n_dut_ho++;
      if (m_full && ordy) m_full = 1'b0;
      if (clr) begin
         win_q.delete();
      end else if (v && exp_rdy) begin
         win_q.push_back(d);
         if (win_q.size() == N) begin
            fold_window(res, sat);
            m_out  = res;
            m_osat = sat;
            m_full = 1'b1;
            win_q.delete();
         end
      end
      @(negedge clk);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_full});
      if (m_full) begin
         chk("out_data", $signed(bus.out_data), m_out);
         chk("out_sat", {31'b0, bus.out_sat}, {31'b0, m_osat});
      end
   endtask

   task automatic window4(input int a, input int b, input int c, input int d);
      cycle(1, a, 1, 0);
      cycle(1, b, 1, 0);
      cycle(1, c, 1, 0);
      cycle(1, d, 1, 0);
   endtask

   initial begin
      int ho0;
      rst           = 1'b1;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #3;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_out_data", $signed(bus.out_data), 0);
      chk("rst_out_sat", {31'b0, bus.out_sat}, 0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Plain sum, one-cycle result pulse
      window4(1, 2, 3, -1);
      chk("t1_valid", {31'b0, bus.out_valid}, 1);
      chk("t1_data", $signed(bus.out_data), 5);
      chk("t1_sat", {31'b0, bus.out_sat}, 0);
      cycle(0, 0, 1, 0);
      chk("t1_pulse_end", {31'b0, bus.out_valid}, 0);

      // Saturation and order dependence
      window4(7, 7, -8, -8);
      chk("t2_data", $signed(bus.out_data), -8);
      chk("t2_sat", {31'b0, bus.out_sat}, 1);
      window4(-8, -8, 7, 7);
      chk("t3_data", $signed(bus.out_data), 6);
      chk("t3_sat", {31'b0, bus.out_sat}, 1);
      cycle(0, 0, 1, 0);

      // Back-to-back windows with a stalled sink
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
      chk("t4_w1_data", $signed(bus.out_data), 4);
      cycle(1, 1, 0, 0);
      cycle(1, 2, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 2, 0, 0);
      chk("t4_stall_ready", {31'b0, bus.in_ready}, 0);
      chk("t4_hold_data", $signed(bus.out_data), 4);
      cycle(1, 2, 0, 0);
      ho0 = n_dut_ho;
      cycle(1, 2, 1, 0);
      chk("t4_ho1", n_dut_ho - ho0, 1);
      chk("t4_reload_valid", {31'b0, bus.out_valid}, 1);
      chk("t4_w2_data", $signed(bus.out_data), 6);
      cycle(0, 0, 1, 0);
      chk("t4_ho2", n_dut_ho - ho0, 2);
      chk("t4_drained", {31'b0, bus.out_valid}, 0);

      // Clear aborts a partial window
      cycle(1, 3, 1, 0);
      cycle(1, 3, 1, 0);
      bus.clear = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      chk("t5_clear_ready", {31'b0, bus.in_ready}, 0);
      @(negedge clk);
      win_q.delete();
      window4(1, 1, 1, 1);
      chk("t5_data", $signed(bus.out_data), 4);
      chk("t5_sat", {31'b0, bus.out_sat}, 0);

      // Asynchronous reset mid-window with a pending result
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0);
      cycle(1, 3, 0, 0);
      cycle(1, 3, 0, 0);
      chk("t6_pre_valid", {31'b0, bus.out_valid}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", {31'b0, bus.out_valid}, 0);
      chk("t6_rst_data", $signed(bus.out_data), 0);
      chk("t6_rst_sat", {31'b0, bus.out_sat}, 0);
      @(negedge clk);
      rst = 1'b0;
      win_q.delete();
      m_full = 1'b0;
      window4(2, 2, -1, 1);
      chk("t6_data", $signed(bus.out_data), 4);
      chk("t6_sat", {31'b0, bus.out_sat}, 0);

      // Randomized traffic against the window model
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 15)) - 8,
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
